// File: rtl/ffcp_rx_buffer_pkg.sv
// rtl/ffcp_rx_buffer_pkg.sv - shared constants, types and helpers for the rx packet buffer
//
// Purpose: FFCP field widths, the per-slot stride, the clog2 helper, the FSM
// state enums and the tag that travels alongside read data.
// Ports: none (package).
package ffcp_rx_buffer_pkg;

  localparam int BYTE_LEN       = 8;
  localparam int FFCP_INDEX_LEN = 6;
  localparam int FFCP_DATA_LEN  = 769;
  localparam int SLOT_STRIDE    = 1024;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int OFFSET_LEN = clog2(SLOT_STRIDE);

  typedef enum logic {
    W_IDLE,
    W_ACTIVE
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ISSUE,
    R_DRAIN
  } rd_state_e;

  // Travels down the delay line in step with the RAM read pipeline.
  typedef struct packed {
    logic last;
    logic valid;
  } rd_tag_t;

endpackage

// File: rtl/ffcp_rx_buffer_if.sv
// rtl/ffcp_rx_buffer_if.sv - write/read handshake bundle of the rx packet buffer
//
// Purpose: groups the ffcp_rx write stream, the rx server commit handshake and
// the downstream pull/output signals.
// Ports (signals):
//   wr_start, wr_index, wr_inclk, wr_in, wr_done : payload write stream
//   commit, commit_index                         : start streaming a slot
//   readclk                                      : downstream pull
//   outclk, out, commit_done, busy               : read-side results
// Modports: master drives the inputs of the buffer, slave is the buffer.
interface ffcp_rx_buffer_if;
  import ffcp_rx_buffer_pkg::*;

  logic                      wr_start;
  logic [FFCP_INDEX_LEN-1:0] wr_index;
  logic                      wr_inclk;
  logic [BYTE_LEN-1:0]       wr_in;
  logic                      wr_done;
  logic                      commit;
  logic [FFCP_INDEX_LEN-1:0] commit_index;
  logic                      readclk;
  logic                      outclk;
  logic [BYTE_LEN-1:0]       out;
  logic                      commit_done;
  logic                      busy;

  modport master (
    output wr_start, wr_index, wr_inclk, wr_in, wr_done,
    output commit, commit_index, readclk,
    input  outclk, out, commit_done, busy
  );

  modport slave (
    input  wr_start, wr_index, wr_inclk, wr_in, wr_done,
    input  commit, commit_index, readclk,
    output outclk, out, commit_done, busy
  );

endinterface

// File: rtl/ffcp_pb_ram.sv
// rtl/ffcp_pb_ram.sv - simple dual-port packet RAM with pipelined read
//
// Purpose: one write port, one read port; read data appears LATENCY cycles
// after the address is presented.  A same-cycle read and write of one address
// returns the old contents.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (read pipe only)
//   wr_en/addr/data   : write port
//   rd_addr           : read address, sampled every cycle
//   rd_data           : read data, LATENCY cycles after rd_addr
module ffcp_pb_ram #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [LATENCY-1:0][DATA_W-1:0] pipe_q;
  logic [LATENCY-1:0][DATA_W-1:0] pipe_d;

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = mem[rd_addr];
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign rd_data = pipe_q[LATENCY-1];

endmodule

// File: rtl/ffcp_rx_buffer.sv
// rtl/ffcp_rx_buffer.sv - FFCP receive-side packet buffer
//
// Purpose: stores each incoming payload in the slot chosen by its FFCP index
// and, on commit, streams one slot downstream under readclk pull, pulsing
// commit_done with the last byte.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : ffcp_rx_buffer_if.slave (write stream, commit, readclk, outputs)
module ffcp_rx_buffer
  import ffcp_rx_buffer_pkg::*;
#(
  parameter int SLOT_COUNT  = 8,
  parameter int DATA_LEN    = FFCP_DATA_LEN,
  parameter int RAM_LATENCY = 2
) (
  input logic              clk,
  input logic              rst,
  ffcp_rx_buffer_if.slave  bus
);

  localparam int SLOT_W = clog2(SLOT_COUNT);
  localparam int ADDR_W = SLOT_W + OFFSET_LEN;
  localparam logic [OFFSET_LEN-1:0] LAST_OFF = OFFSET_LEN'(DATA_LEN - 1);

  wr_state_e             wr_state_q, wr_state_d;
  logic [SLOT_W-1:0]     wr_slot_q, wr_slot_d;
  logic [OFFSET_LEN-1:0] wr_off_q, wr_off_d;
  logic                  ram_wr_en;

  rd_state_e             rd_state_q, rd_state_d;
  logic [SLOT_W-1:0]     rd_slot_q, rd_slot_d;
  logic [OFFSET_LEN-1:0] rd_off_q, rd_off_d;
  logic                  rd_issue;
  logic                  rd_issue_last;

  rd_tag_t [RAM_LATENCY-1:0] tag_q, tag_d;
  rd_tag_t                   tag_out;

  logic [BYTE_LEN-1:0] ram_rd_data;

  // Write side.  wr_start restarts from any state and wins over a same-cycle
  // byte.  The offset stops advancing at DATA_LEN so surplus bytes are dropped.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_slot_d  = wr_slot_q;
    wr_off_d   = wr_off_q;
    ram_wr_en  = 1'b0;
    if (bus.wr_start) begin
      wr_state_d = W_ACTIVE;
      wr_slot_d  = SLOT_W'(int'(bus.wr_index) % SLOT_COUNT);
      wr_off_d   = '0;
    end else if (wr_state_q == W_ACTIVE && bus.wr_inclk) begin
      if (wr_off_q <= LAST_OFF) begin
        ram_wr_en = 1'b1;
        wr_off_d  = wr_off_q + 1'b1;
      end
      if (bus.wr_done) begin
        wr_state_d = W_IDLE;
      end
    end
  end

  // Read side.  Reads are issued one per readclk; the tag line marks which
  // pipeline slots carry real data and which one is the final byte.
  always_comb begin
    rd_state_d    = rd_state_q;
    rd_slot_d     = rd_slot_q;
    rd_off_d      = rd_off_q;
    rd_issue      = 1'b0;
    rd_issue_last = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (bus.commit) begin
          rd_state_d = R_ISSUE;
          rd_slot_d  = SLOT_W'(int'(bus.commit_index) % SLOT_COUNT);
          rd_off_d   = '0;
        end
      end
      R_ISSUE: begin
        if (bus.readclk) begin
          rd_issue = 1'b1;
          rd_off_d = rd_off_q + 1'b1;
          if (rd_off_q == LAST_OFF) begin
            rd_issue_last = 1'b1;
            rd_state_d    = R_DRAIN;
          end
        end
      end
      R_DRAIN: begin
        if (tag_out.last) begin
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase

    tag_d          = '0;
    tag_d[0].valid = rd_issue;
    tag_d[0].last  = rd_issue_last;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      wr_slot_q  <= '0;
      wr_off_q   <= '0;
      rd_state_q <= R_IDLE;
      rd_slot_q  <= '0;
      rd_off_q   <= '0;
      tag_q      <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_slot_q  <= wr_slot_d;
      wr_off_q   <= wr_off_d;
      rd_state_q <= rd_state_d;
      rd_slot_q  <= rd_slot_d;
      rd_off_q   <= rd_off_d;
      tag_q      <= tag_d;
    end
  end

  ffcp_pb_ram #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (BYTE_LEN),
    .LATENCY (RAM_LATENCY)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_wr_en),
    .wr_addr ({wr_slot_q, wr_off_q}),
    .wr_data (bus.wr_in),
    .rd_addr ({rd_slot_q, rd_off_q}),
    .rd_data (ram_rd_data)
  );

  assign tag_out         = tag_q[RAM_LATENCY-1];
  assign bus.outclk      = tag_out.valid;
  assign bus.commit_done = tag_out.last;
  assign bus.out         = ram_rd_data;
  assign bus.busy        = (rd_state_q != R_IDLE);

endmodule

// File: tb/tb_ffcp_rx_buffer.sv
// tb/tb_ffcp_rx_buffer.sv - self-checking bench for ffcp_rx_buffer
module tb_ffcp_rx_buffer;
  import ffcp_rx_buffer_pkg::*;

  localparam int SLOTS   = 8;
  localparam int DLEN    = FFCP_DATA_LEN;
  localparam int RAM_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ffcp_rx_buffer_if bus();

  ffcp_rx_buffer #(
    .SLOT_COUNT  (SLOTS),
    .DATA_LEN    (DLEN),
    .RAM_LATENCY (RAM_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference: contents of each slot as the write rules say they must be.
  int          model [SLOTS][DLEN];
  logic [7:0]  wr_buf [1024];

  typedef struct {
    int wr_idx;
    int pat;
    int rd_idx;
    int rc_mode;
    int exp0;
    int exp768;
  } vec_t;

  vec_t tbl [4];

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic int pat_byte(int mode, int k);
    case (mode)
      0:       return k & 255;
      1:       return 8'hA5;
      2:       return (k >> 2) & 255;
      default: return ((k >> 1) + 17) & 255;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pat(int mode);
    for (int k = 0; k < 1024; k++) wr_buf[k] = 8'(pat_byte(mode, k));
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 1024; k++) wr_buf[k] = 8'($urandom_range(0, 255));
  endtask

  task automatic write_pkt(input int idx, input int n, input bit with_done, input bit gaps);
    bus.wr_start = 1'b1;
    bus.wr_index = 6'(idx);
    step();
    bus.wr_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          bus.wr_inclk = 1'b0;
          bus.wr_done  = 1'b0;
          step();
        end
      end
      bus.wr_inclk = 1'b1;
      bus.wr_in    = wr_buf[k];
      bus.wr_done  = with_done && (k == n - 1);
      if (k < DLEN) model[idx % SLOTS][k] = int'(wr_buf[k]);
      step();
    end
    bus.wr_inclk = 1'b0;
    bus.wr_done  = 1'b0;
  endtask

  // rc_mode: 0 readclk held high, 1 toggles 1-0-1-0, 2 random.
  // reset_at >= 0 pulses rst once that many reads have been issued.
  task automatic read_pkt(input int idx, input int rc_mode, input int reset_at,
                          input bit chk_lat, output int g0, output int g768);
    int exp_q[$];
    int got_q[$];
    int due_q[$];
    int issued, first_c, done_c, n_done, bad_t, k, slot, nbad, quiet;
    bit done_ok, busy_ok, rc;
    issued = 0; first_c = -1; done_c = -1; n_done = 0; bad_t = 0;
    done_ok = 1'b0; busy_ok = 1'b1; g0 = -1; g768 = -1;
    slot = idx % SLOTS;
    for (int j = 0; j < DLEN; j++) exp_q.push_back(model[slot][j]);

    bus.commit       = 1'b1;
    bus.commit_index = 6'(idx);
    bus.readclk      = (rc_mode == 0);
    step();
    bus.commit = 1'b0;
    k = 1;
    while (1) begin
      if (bus.outclk) begin
        got_q.push_back(int'(bus.out));
        if (first_c < 0) first_c = k;
      end
      if (due_q.size() > 0 && due_q[0] == k) begin
        if (!bus.outclk) bad_t++;
        void'(due_q.pop_front());
      end else if (bus.outclk) begin
        bad_t++;
      end
      if (bus.commit_done) begin
        n_done++;
        done_c  = k;
        done_ok = bus.outclk && (got_q.size() == DLEN);
        if (!bus.busy) busy_ok = 1'b0;
      end
      if (done_c >= 0 && k == done_c + 1) begin
        if (bus.busy) busy_ok = 1'b0;
        break;
      end
      if (k > 4 * DLEN + 20) begin
        check("read_timeout", k, 4 * DLEN + 20);
        break;
      end
      if (reset_at >= 0 && issued == reset_at) begin
        rst         = 1'b1;
        bus.readclk = 1'b0;
        step();
        rst = 1'b0;
        check("rst_outclk", int'(bus.outclk), 0);
        check("rst_busy", int'(bus.busy), 0);
        quiet = n_done;
        for (int j = 0; j < 8; j++) begin
          if (bus.outclk || bus.commit_done) quiet++;
          step();
        end
        check("rst_quiet", quiet, 0);
        return;
      end
      case (rc_mode)
        0:       rc = 1'b1;
        1:       rc = k[0];
        default: rc = 1'($urandom_range(0, 1));
      endcase
      bus.readclk = rc;
      if (rc && issued < DLEN) begin
        issued++;
        due_q.push_back(k + RAM_LAT);
      end
      step();
      k++;
    end
    bus.readclk = 1'b0;

    nbad = 0;
    for (int j = 0; j < DLEN && j < got_q.size(); j++) begin
      if (got_q[j] != exp_q[j]) nbad++;
    end
    check("beat_count", got_q.size(), DLEN);
    check("stream_data_bad_bytes", nbad, 0);
    check("beat_timing_errors", bad_t + due_q.size(), 0);
    check("commit_done_count", n_done, 1);
    check("commit_done_on_last", int'(done_ok), 1);
    check("busy_drop", int'(busy_ok), 1);
    if (chk_lat) begin
      check("first_beat_latency", first_c, 1 + RAM_LAT);
      check("commit_done_latency", done_c, DLEN + RAM_LAT);
    end
    if (got_q.size() > 0) g0 = got_q[0];
    if (got_q.size() > 768) g768 = got_q[768];
  endtask

  initial begin
    int g0, g768, idx;

    tbl[0] = '{3, 0, 3, 0, 0, 0};          // k mod 256, readclk held
    tbl[1] = '{11, 1, 3, 1, 8'hA5, 8'hA5}; // alias of slot 3, toggled pull
    tbl[2] = '{63, 2, 7, 2, 0, 192};       // wrap: index 63 -> slot 7
    tbl[3] = '{8, 3, 0, 2, 8'h11, 8'h91};  // index 8 -> slot 0

    bus.wr_start = 1'b0; bus.wr_index = '0; bus.wr_inclk = 1'b0;
    bus.wr_in = '0; bus.wr_done = 1'b0; bus.commit = 1'b0;
    bus.commit_index = '0; bus.readclk = 1'b0;

    rst = 1'b1;
    repeat (3) step();
    check("reset_outclk", int'(bus.outclk), 0);
    check("reset_commit_done", int'(bus.commit_done), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_out", int'(bus.out), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) begin
      fill_pat(tbl[i].pat);
      write_pkt(tbl[i].wr_idx, DLEN, 1'b1, 1'b0);
      step();
      read_pkt(tbl[i].rd_idx, tbl[i].rc_mode, -1, (i == 0), g0, g768);
      check($sformatf("row%0d_byte0", i), g0, tbl[i].exp0);
      check($sformatf("row%0d_byte768", i), g768, tbl[i].exp768);
      step();
    end

    // Write slot 1 while slot 0 streams out; then read slot 1 back.
    fill_rand();
    fork
      read_pkt(0, 0, -1, 1'b0, g0, g768);
      write_pkt(1, DLEN, 1'b1, 1'b1);
    join
    step();
    read_pkt(1, 2, -1, 1'b0, g0, g768);

    // Reset in the middle of a stream, then a clean restart from offset 0.
    fill_rand();
    write_pkt(2, DLEN, 1'b1, 1'b0);
    step();
    read_pkt(2, 0, 100, 1'b0, g0, g768);
    read_pkt(2, 0, -1, 1'b1, g0, g768);

    // Abort a write with a fresh wr_start, then overrun the new packet.
    fill_rand();
    write_pkt(5, 300, 1'b0, 1'b0);
    fill_rand();
    write_pkt(5, DLEN + 2, 1'b1, 1'b0);
    step();
    read_pkt(5, 1, -1, 1'b0, g0, g768);

    // Random packets to random indices, random pull pattern.
    for (int r = 0; r < 4; r++) begin
      idx = $urandom_range(0, 63);
      fill_rand();
      write_pkt(idx, DLEN, 1'b1, 1'b1);
      repeat ($urandom_range(0, 3)) step();
      read_pkt(idx, 2, -1, 1'b0, g0, g768);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
